// File: rtl/sm_seq_driver.sv
// sm_seq_driver: drives a/b/c through the WAIT/START/DOIT/DONE handshake and counts completed sequences.
// Define SM_SEQ_DRIVER_TIMEOUT_EN to add the per-step wait counter and the terminal ERR state.
module sm_seq_driver #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic ctrl_1,
  input  logic ctrl_2,
  output logic a,
  output logic b,
  output logic c,
  output logic busy,
  output logic done,
  output logic error,
  output logic [CNT_W-1:0] seq_count
);
  typedef enum logic [2:0] {IDLE, S_A, S_AB, S_ABC, S_B, ERR} state_t;
  state_t state, state_nx;
  logic [1:0] exp_code;
  logic [2:0] abc_nx;
  logic drive, match, busy_nx, done_nx;
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 2..255");
  end
  assign drive = state inside {S_A, S_AB, S_ABC, S_B};
  assign exp_code = state == S_A ? 2'b10 : state == S_AB ? 2'b01 : state == S_ABC ? 2'b11 : 2'b00;
  assign match = drive && {ctrl_1, ctrl_2} == exp_code;
`ifdef SM_SEQ_DRIVER_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic timeout;
  assign timeout = drive && wait_cnt == 8'(TIMEOUT - 1);
  // The counter restarts whenever the state changes, so it measures time spent in the current step.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wait_cnt <= '0;
      error <= 1'b0;
    end else begin
      wait_cnt <= (drive && state_nx == state) ? wait_cnt + 8'd1 : 8'd0;
      error <= state_nx == ERR;
    end
`else
  logic timeout;
  assign timeout = 1'b0;
  assign error = 1'b0;
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      {a, b, c} <= 3'b000;
      busy <= 1'b0;
      done <= 1'b0;
      seq_count <= '0;
    end else begin
      state <= state_nx;
      {a, b, c} <= abc_nx;
      busy <= busy_nx;
      done <= done_nx;
      seq_count <= seq_count + CNT_W'(done_nx);
    end
  // A match on the timeout edge still advances: match is tested first.
  always_comb begin
    state_nx = state;
    if (state == IDLE && start) state_nx = S_A;
    else if (match) state_nx = state == S_A ? S_AB : state == S_AB ? S_ABC : state == S_ABC ? S_B : IDLE;
    else if (timeout) state_nx = ERR;
  end
  always_comb begin
    abc_nx = state_nx == S_A ? 3'b100 : state_nx == S_AB ? 3'b110 :
             state_nx == S_ABC ? 3'b111 : state_nx == S_B ? 3'b010 : 3'b000;
    busy_nx = state_nx inside {S_A, S_AB, S_ABC, S_B};
    done_nx = state == S_B && match;
  end
endmodule

// File: tb/tb_sm_seq_driver.sv
// tb_sm_seq_driver: directed tables and random traffic against a step-index reference model.
module tb_sm_seq_driver;
`ifdef SM_SEQ_DRIVER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TIMEOUT = 15;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [1:0] ctrl;
  logic a, b, c, busy, done, error;
  logic [7:0] seq_count;
  logic a2, b2, c2, busy2, done2, error2;
  logic [1:0] seq_count2;
  logic hold = 1'b0, rnd = 1'b0, auto_en = 1'b0;
  logic [1:0] hold_val = 2'b00;
  int n_cmp = 0, n_bad = 0;
  int m_step, m_wait;
  logic m_done, m_err;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  sm_seq_driver #(.TIMEOUT(TIMEOUT), .CNT_W(8)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .ctrl_1(ctrl[1]), .ctrl_2(ctrl[0]),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .error(error), .seq_count(seq_count));
  sm_seq_driver #(.TIMEOUT(TIMEOUT), .CNT_W(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .start(start), .ctrl_1(ctrl[1]), .ctrl_2(ctrl[0]),
    .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .error(error2), .seq_count(seq_count2));

  // Step k of the handshake: what is driven and what must come back.
  function automatic logic [2:0] drv(int k);
    return k == 1 ? 3'b100 : k == 2 ? 3'b110 : k == 3 ? 3'b111 : k == 4 ? 3'b010 : 3'b000;
  endfunction
  function automatic logic [1:0] want(int k);
    return k == 1 ? 2'b10 : k == 2 ? 2'b01 : k == 3 ? 2'b11 : 2'b00;
  endfunction
  function automatic logic [1:0] respond(logic [2:0] abc);
    for (int k = 1; k <= 4; k++) if (drv(k) == abc) return want(k);
    return 2'b00;
  endfunction

  // Controlled machine: answers one edge after seeing a/b/c.
  always @(posedge clk or negedge resetn)
    if (!resetn) ctrl <= 2'b00;
    else if (hold) ctrl <= hold_val;
    else if (rnd) ctrl <= 2'($urandom_range(0, 3));
    else ctrl <= respond({a, b, c});

  always @(posedge clk or negedge resetn)
    if (!resetn) begin
      m_step <= 0; m_wait <= 0; m_done <= 1'b0; m_err <= 1'b0; m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_step == 0) begin
        if (start) begin m_step <= 1; m_wait <= 0; end
      end else if (m_step <= 4) begin
        if (ctrl == want(m_step)) begin
          m_wait <= 0;
          m_step <= m_step == 4 ? 0 : m_step + 1;
          if (m_step == 4) begin m_done <= 1'b1; m_cnt <= m_cnt + 1; end
        end else if (TO_EN && m_wait == TIMEOUT - 1) begin
          m_step <= 5; m_err <= 1'b1;
        end else m_wait <= m_wait + 1;
      end
    end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (auto_en) begin
      chk("m_abc", {a, b, c}, drv(m_step));
      chk("m_busy", busy, m_step >= 1 && m_step <= 4);
      chk("m_done", done, m_done);
      chk("m_error", error, m_err);
      chk("m_count", seq_count, m_cnt[7:0]);
      chk("m_count2", seq_count2, m_cnt[1:0]);
      chk("m_abc2", {a2, b2, c2, busy2, done2, error2}, {drv(m_step), m_step >= 1 && m_step <= 4, m_done, m_err});
    end

  task automatic wait_abc(logic [2:0] v, string nm);
    for (int i = 0; i < 40; i++) begin
      if ({a, b, c} == v) return;
      @(negedge clk);
    end
    chk(nm, {a, b, c}, v);
  endtask

  typedef struct {logic [2:0] abc; logic busy; logic done;} vec_t;
  vec_t tbl[10];
  int dn;

  initial begin
    tbl[0] = '{3'b100, 1'b1, 1'b0}; tbl[1] = '{3'b100, 1'b1, 1'b0};
    tbl[2] = '{3'b110, 1'b1, 1'b0}; tbl[3] = '{3'b110, 1'b1, 1'b0};
    tbl[4] = '{3'b111, 1'b1, 1'b0}; tbl[5] = '{3'b111, 1'b1, 1'b0};
    tbl[6] = '{3'b010, 1'b1, 1'b0}; tbl[7] = '{3'b010, 1'b1, 1'b0};
    tbl[8] = '{3'b000, 1'b0, 1'b1}; tbl[9] = '{3'b000, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_outs", {a, b, c, busy, done, error, seq_count}, 0);
    resetn = 1'b1;
    auto_en = 1'b1;
    // Single sequence, one step per table row.
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("tbl_abc[%0d]", k), {a, b, c}, tbl[k].abc);
      chk($sformatf("tbl_busy[%0d]", k), busy, tbl[k].busy);
      chk($sformatf("tbl_done[%0d]", k), done, tbl[k].done);
    end
    chk("tbl_count", seq_count, 1);
    // Asynchronous reset mid-sequence takes effect before the next edge.
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); start = 1'b0;
    #2 resetn = 1'b0;
    #1 chk("async_rst", {a, b, c, busy, done, error, seq_count}, 0);
    @(negedge clk); resetn = 1'b1;
    // Back-to-back: each new start is accepted in the cycle done is high.
    start = 1'b1;
    dn = 0;
    for (int e = 0; e <= 44; e++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("b2b_done[%0d]", e), done, e % 9 == 8);
      if (e % 9 == 8) begin
        dn++;
        chk($sformatf("b2b_cnt[%0d]", e), seq_count, dn);
        chk($sformatf("b2b_cnt2[%0d]", e), seq_count2, dn % 4);
        if (e == 44) start = 1'b0;
      end
      else if (e % 9 == 0) chk($sformatf("b2b_busy[%0d]", e), busy, 1);
    end
`ifdef SM_SEQ_DRIVER_TIMEOUT_EN
    // Stall in S_AB until the step times out.
    start = 1'b1;
    wait_abc(3'b110, "to_enter");
    start = 1'b0; hold = 1'b1; hold_val = 2'b10;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("to_err[%0d]", i), error, i == 15);
    end
    chk("to_outs", {a, b, c, busy}, 0);
    start = 1'b1;
    repeat (4) @(negedge clk);
    chk("to_sticky", {error, busy}, 2'b10);
    start = 1'b0; hold = 1'b0;
    resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    chk("to_clear", error, 0);
    // Match on the would-be timeout edge.
    start = 1'b1;
    wait_abc(3'b110, "race_enter");
    start = 1'b0; hold = 1'b1; hold_val = 2'b10;
    repeat (13) @(posedge clk);
    @(negedge clk); hold = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("race_pre", {a, b, c, error}, 4'b1100);
    @(posedge clk); @(negedge clk);
    chk("race_adv", {a, b, c, error}, 4'b1110);
    repeat (6) @(negedge clk);
    chk("race_done", seq_count, m_cnt[7:0]);
`else
    // Without the timeout a stalled step waits indefinitely.
    start = 1'b1;
    wait_abc(3'b100, "stall_enter");
    start = 1'b0; hold = 1'b1; hold_val = 2'b00;
    repeat (100) @(negedge clk);
    chk("stall_hold", {a, b, c, busy, error}, 5'b10010);
    dn = int'(seq_count);
    hold = 1'b0;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk("stall_done", done, 1);
    chk("stall_cnt", seq_count, dn + 1);
`endif
    // Random traffic: random start, stalls, noisy ctrl and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = $urandom_range(0, 3) == 0;
      rnd = $urandom_range(0, 5) == 0;
      hold = $urandom_range(0, 7) == 0;
      hold_val = 2'($urandom_range(0, 3));
      resetn = $urandom_range(0, 149) != 0;
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
